// File: rtl/i2c_regfile_ctrl.sv
// Register-file controller between the I2C slave byte datapath and a shared single-port bank.
// I2C gets pointer/auto-increment writes and reads; a local host port uses leftover bank cycles.
module i2c_regfile_ctrl #(
   parameter int unsigned           AW      = 4,
   parameter int unsigned           DW      = 8,
   parameter logic [(2**AW)-1:0]    RO_MASK = '0
) (
   input  logic          CLCK,
   input  logic          RSTN,
   input  logic          i2c_start,
   input  logic          i2c_rw,
   input  logic          i2c_stop,
   input  logic          i2c_rx_valid,
   input  logic [7:0]    i2c_rx_data,
   input  logic          i2c_tx_req,
   output logic [7:0]    i2c_tx_data,
   output logic          i2c_tx_valid,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic          rf_en,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_wdata,
   input  logic [DW-1:0] rf_rdata,
   output logic          wr_strobe,
   output logic [AW-1:0] wr_addr,
   output logic          busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PTR   = 2'd1;
   localparam logic [1:0] S_WDATA = 2'd2;
   localparam logic [1:0] S_RDATA = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_host_q, rd_host_d;
   logic          i2c_en, i2c_we;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      i2c_en  = 1'b0;
      i2c_we  = 1'b0;
      // Events are gated by RSTN so nothing, including a host grant, escapes during reset.
      if (RSTN) begin
         if (i2c_stop) begin
            state_d = S_IDLE;
         end else if (i2c_start) begin
            state_d = i2c_rw ? S_RDATA : S_PTR;
         end else begin
            case (state_q)
               S_PTR: begin
                  if (i2c_rx_valid) begin
                     ptr_d   = i2c_rx_data[AW-1:0];
                     state_d = S_WDATA;
                  end
               end
               S_WDATA: begin
                  if (i2c_rx_valid) begin
                     ptr_d = ptr_q + AW'(1);
                     if (!RO_MASK[ptr_q]) begin
                        i2c_en = 1'b1;
                        i2c_we = 1'b1;
                     end
                  end
               end
               S_RDATA: begin
                  if (i2c_tx_req && !i2c_rx_valid) begin
                     i2c_en = 1'b1;
                     ptr_d  = ptr_q + AW'(1);
                  end
               end
               default: ;
            endcase
         end
      end

      host_gnt  = RSTN & host_req & ~i2c_en;
      wr_strobe = i2c_en & i2c_we;
      wr_addr_d = wr_strobe ? ptr_q : wr_addr_q;
      wr_addr   = wr_addr_d;

      rf_en    = i2c_en | host_gnt;
      rf_we    = i2c_en ? i2c_we : (host_gnt & host_we);
      rf_addr  = i2c_en ? ptr_q : (host_gnt ? host_addr : '0);
      rf_wdata = i2c_en ? DW'(i2c_rx_data) : ((host_gnt & host_we) ? host_wdata : '0);

      // Owner tag travels with each read so the returning rf_rdata goes to the right side.
      rd_pend_d = (i2c_en & ~i2c_we) | (host_gnt & ~host_we);
      rd_host_d = host_gnt & ~host_we;

      tx_valid_d  = rd_pend_q & ~rd_host_q;
      tx_data_d   = tx_valid_d ? rf_rdata[7:0] : tx_data_q;
      host_rvalid = rd_pend_q & rd_host_q;
      host_rdata  = host_rvalid ? rf_rdata : '0;

      i2c_tx_data  = tx_data_q;
      i2c_tx_valid = tx_valid_q;
      busy         = (state_q != S_IDLE);
   end

   always_ff @(posedge CLCK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         wr_addr_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_host_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wr_addr_q  <= wr_addr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         rd_pend_q  <= rd_pend_d;
         rd_host_q  <= rd_host_d;
      end
   end

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Scoreboard bench for i2c_regfile_ctrl: random I2C/host traffic against a behavioural register
// model; a negedge monitor pops expected tx bytes, host read data and write strobes.
module tb_i2c_regfile_ctrl;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;
   localparam logic [15:0] RO = 16'h0010;

   logic          CLCK, RSTN;
   logic          i2c_start, i2c_rw, i2c_stop, i2c_rx_valid, i2c_tx_req;
   logic [7:0]    i2c_rx_data, i2c_tx_data;
   logic          i2c_tx_valid;
   logic          host_req, host_we, host_gnt, host_rvalid;
   logic [AW-1:0] host_addr, rf_addr, wr_addr;
   logic [DW-1:0] host_wdata, host_rdata, rf_wdata, rf_rdata;
   logic          rf_en, rf_we, wr_strobe, busy;

   i2c_regfile_ctrl #(.AW(AW), .DW(DW), .RO_MASK(RO)) dut (
      .CLCK(CLCK), .RSTN(RSTN),
      .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
      .i2c_rx_valid(i2c_rx_valid), .i2c_rx_data(i2c_rx_data),
      .i2c_tx_req(i2c_tx_req), .i2c_tx_data(i2c_tx_data), .i2c_tx_valid(i2c_tx_valid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
   );

   typedef struct { logic [7:0] d; int cyc; } exp_t;
   exp_t       tx_q[$];
   logic [7:0] hr_q[$];
   int         wr_q[$];

   logic [7:0] mem[16];
   logic [7:0] ref_bank[16];
   int         ref_ptr;
   int         mode;   // 0 idle, 1 expecting pointer, 2 writing, 3 reading
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   initial begin
      CLCK = 0;
      forever #5 CLCK = ~CLCK;
   end

   always @(posedge CLCK) cyc <= cyc + 1;

   // Bank environment: single-port RAM with one-cycle read latency.
   always @(posedge CLCK) begin
      if (rf_en) begin
         if (rf_we) mem[rf_addr] <= rf_wdata;
         else       rf_rdata     <= mem[rf_addr];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge CLCK) begin : mon
      exp_t e;
      int   a;
      logic [7:0] h;
      if (i2c_tx_valid) begin
         if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
         else begin
            e = tx_q.pop_front();
            chk("tx_data", int'(i2c_tx_data), int'(e.d));
            chk("tx_latency", cyc, e.cyc);
         end
      end
      if (host_rvalid) begin
         if (hr_q.size() == 0) chk("host_rvalid_unexpected", 1, 0);
         else begin
            h = hr_q.pop_front();
            chk("host_rdata", int'(host_rdata), int'(h));
         end
      end
      if (wr_strobe) begin
         if (wr_q.size() == 0) chk("wr_strobe_unexpected", 1, 0);
         else begin
            a = wr_q.pop_front();
            chk("wr_addr", int'(wr_addr), a);
            chk("wr_bank_strobe", int'({rf_en, rf_we}), 3);
         end
      end
   end

   task automatic tick();
      @(posedge CLCK);
      #1;
   endtask

   task automatic i2c_start_t(input bit rw);
      i2c_start = 1; i2c_rw = rw;
      mode = rw ? 3 : 1;
      tick();
      i2c_start = 0; i2c_rw = 0;
   endtask

   task automatic i2c_stop_t();
      i2c_stop = 1; mode = 0;
      tick();
      i2c_stop = 0;
   endtask

   task automatic i2c_rx(input logic [7:0] b);
      if (mode == 1) begin
         ref_ptr = b % 16;
         mode = 2;
      end else if (mode == 2) begin
         if (!RO[ref_ptr]) begin
            ref_bank[ref_ptr] = b;
            wr_q.push_back(ref_ptr);
         end
         ref_ptr = (ref_ptr + 1) % 16;
      end
      i2c_rx_valid = 1; i2c_rx_data = b;
      tick();
      i2c_rx_valid = 0; i2c_rx_data = '0;
   endtask

   task automatic i2c_tx();
      exp_t e;
      if (mode == 3) begin
         e.d = ref_bank[ref_ptr];
         e.cyc = cyc + 2;
         tx_q.push_back(e);
         ref_ptr = (ref_ptr + 1) % 16;
      end
      i2c_tx_req = 1;
      tick();
      i2c_tx_req = 0;
   endtask

   task automatic host_access(input bit we, input int a, input logic [7:0] d);
      bit got = 0;
      if (we) ref_bank[a] = d;
      else    hr_q.push_back(ref_bank[a]);
      host_req = 1; host_we = we; host_addr = AW'(a); host_wdata = d;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (host_gnt) begin got = 1; break; end
         @(posedge CLCK); #1;
      end
      if (!got) chk("host_gnt_timeout", 0, 1);
      @(posedge CLCK); #1;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   initial begin
      RSTN = 0;
      i2c_start = 0; i2c_rw = 0; i2c_stop = 0; i2c_rx_valid = 0; i2c_rx_data = '0; i2c_tx_req = 0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      mode = 0; ref_ptr = 0;
      for (int i = 0; i < 16; i++) begin
         ref_bank[i] = 8'($urandom);
         mem[i] = ref_bank[i];
      end
      repeat (3) tick();
      RSTN = 1;
      tick();
      chk("reset_tx_data", int'(i2c_tx_data), 0);
      chk("reset_tx_valid", int'(i2c_tx_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_rf_en", int'(rf_en), 0);
      chk("reset_wr_addr", int'(wr_addr), 0);
      chk("reset_host_gnt", int'(host_gnt), 0);

      // Reset in the middle of a write burst.
      i2c_start_t(0); i2c_rx(8'h07); i2c_rx(8'hC3);
      chk("busy_wdata", int'(busy), 1);
      RSTN = 0; #2;
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_wr_addr", int'(wr_addr), 0);
      tick();
      RSTN = 1; mode = 0; ref_ptr = 0;
      tick();
      chk("post_reset_busy", int'(busy), 0);
      chk("post_reset_tx_data", int'(i2c_tx_data), 0);
      chk("post_reset_wr_addr", int'(wr_addr), 0);
      i2c_start_t(1); i2c_tx(); i2c_stop_t();   // pointer back at 0

      // Basic write burst, then read back from pointer 5.
      i2c_start_t(0); i2c_rx(8'h03); i2c_rx(8'hA5); i2c_rx(8'h5A);
      i2c_start_t(1); i2c_tx(); tick(); i2c_stop_t();

      // Repeated-START read-back.
      i2c_start_t(0); i2c_rx(8'h03); i2c_start_t(1); i2c_tx(); i2c_tx(); repeat (2) tick(); i2c_stop_t();

      // Pointer wrap 15 -> 0, with upper pointer bits dropped.
      i2c_start_t(0); i2c_rx(8'hFF); i2c_rx(8'h11); i2c_rx(8'h22);
      i2c_start_t(1); i2c_tx(); i2c_tx(); repeat (2) tick(); i2c_stop_t();

      // Read-only register 4 stays untouched but still advances the pointer.
      i2c_start_t(0); i2c_rx(8'h04); i2c_rx(8'h77); i2c_rx(8'h88);
      i2c_start_t(1); i2c_tx(); i2c_tx(); repeat (2) tick(); i2c_stop_t();

      // STOP beats START; stray rx in IDLE is ignored.
      i2c_start = 1; i2c_stop = 1; mode = 0;
      tick();
      i2c_start = 0; i2c_stop = 0;
      chk("stop_priority_busy", int'(busy), 0);
      i2c_rx(8'h99); tick();

      // Contention: I2C read and held host read in the same cycle.
      i2c_start_t(0); i2c_rx(8'h03); i2c_start_t(1);
      hr_q.push_back(ref_bank[5]);
      host_req = 1; host_we = 0; host_addr = 4'd5;
      begin
         exp_t e;
         e.d = ref_bank[ref_ptr]; e.cyc = cyc + 2; tx_q.push_back(e);
      end
      i2c_tx_req = 1;
      #1;
      chk("contend_host_gnt_low", int'(host_gnt), 0);
      chk("contend_i2c_addr", int'(rf_addr), ref_ptr);
      ref_ptr = (ref_ptr + 1) % 16;
      tick();
      i2c_tx_req = 0;
      #1;
      chk("contend_host_gnt_next", int'(host_gnt), 1);
      chk("contend_host_addr", int'(rf_addr), 5);
      @(posedge CLCK); #1;
      host_req = 0; host_addr = '0;
      tick(); i2c_stop_t();

      // Randomised traffic.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0: begin
               i2c_start_t(0); i2c_rx(8'($urandom));
               repeat ($urandom_range(1, 4)) i2c_rx(8'($urandom));
               if ($urandom_range(0, 1) == 1) i2c_stop_t();
            end
            1: begin
               i2c_start_t(1);
               fork
                  begin
                     repeat ($urandom_range(1, 4)) begin i2c_tx(); gap(); end
                  end
                  begin
                     if ($urandom_range(0, 1) == 1) host_access(0, $urandom_range(0, 15), 8'h00);
                  end
               join
               repeat (2) tick();
               i2c_stop_t();
            end
            2: host_access(1, $urandom_range(0, 15), 8'($urandom));
            default: host_access(0, $urandom_range(0, 15), 8'h00);
         endcase
         gap();
      end

      for (int i = 0; i < 20; i++) begin
         if (tx_q.size() == 0 && hr_q.size() == 0 && wr_q.size() == 0) break;
         tick();
      end
      chk("tx_queue_drained", tx_q.size(), 0);
      chk("host_queue_drained", hr_q.size(), 0);
      chk("wr_queue_drained", wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
